// File: rtl/fetch_stage_if.sv
// Instruction-memory read bus between the fetch stage (master) and a
// synchronous instruction memory with one cycle of read latency (slave).
interface fetch_stage_if #(
    parameter int PC_W = 32
);
    logic            imem_en;
    logic [PC_W-1:0] imem_addr;
    logic [31:0]     imem_rdata;

    modport master (
        output imem_en,
        output imem_addr,
        input  imem_rdata
    );

    modport slave (
        input  imem_en,
        input  imem_addr,
        output imem_rdata
    );
endinterface

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, issues one read per cycle to a
// 1-cycle-latency instruction memory, redirects on taken branches, and keeps
// a one-entry skid buffer so the word in flight when a stall arrives is not lost.
// Optional build macro FETCH_PERF_EN adds saturating fetch/bubble counters.
module fetch_stage #(
    parameter int              PC_W      = 32,
    parameter logic [PC_W-1:0] RESET_PC  = '0,
    parameter logic [31:0]     NOP_INSTR = 32'h6800_0000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              branch_taken,
    input  logic [PC_W-1:0]   branch_pc,
    fetch_stage_if.master     imem,
    output logic              if_valid,
    output logic [PC_W-1:0]   if_pc,
    output logic [31:0]       if_instr,
    output logic [4:0]        if_opcode,
    output logic              if_imm
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]       perf_fetch_cnt,
    output logic [31:0]       perf_bubble_cnt
`endif
);

    logic [PC_W-1:0] pc_q, pc_d;
    logic            req_v_q, req_v_d;
    logic [PC_W-1:0] req_pc_q, req_pc_d;
    logic            skid_v_q, skid_v_d;
    logic [PC_W-1:0] skid_pc_q, skid_pc_d;
    logic [31:0]     skid_instr_q, skid_instr_d;
    logic            if_valid_q, if_valid_d;
    logic [PC_W-1:0] if_pc_q, if_pc_d;
    logic [31:0]     if_instr_q, if_instr_d;

    logic            fetch_en;
    logic [PC_W-1:0] branch_target;

    // A request goes out only when nothing holds or squashes this cycle.
    assign fetch_en       = !rst && !stall && !branch_taken;
    assign branch_target  = branch_pc & ~PC_W'(3);
    assign imem.imem_en   = fetch_en;
    assign imem.imem_addr = pc_q;

    // Next PC: redirect beats stall; sequential fetch wraps naturally at 2^PC_W.
    always_comb begin
        pc_d = pc_q;
        if (branch_taken) begin
            pc_d = branch_target;
        end else if (!stall) begin
            pc_d = pc_q + PC_W'(4);
        end
    end

    // Remember whether (and where) a read was issued, so next cycle's data can be tagged.
    always_comb begin
        req_v_d  = fetch_en;
        req_pc_d = pc_q;
    end

    // Route the returning word: squash on redirect, park it while stalled,
    // otherwise feed the output register (skid entry first, it is older).
    always_comb begin
        skid_v_d     = skid_v_q;
        skid_pc_d    = skid_pc_q;
        skid_instr_d = skid_instr_q;
        if_valid_d   = if_valid_q;
        if_pc_d      = if_pc_q;
        if_instr_d   = if_instr_q;
        if (branch_taken) begin
            skid_v_d   = 1'b0;
            if_valid_d = 1'b0;
            if_instr_d = NOP_INSTR;
        end else if (stall) begin
            if (req_v_q) begin
                skid_v_d     = 1'b1;
                skid_pc_d    = req_pc_q;
                skid_instr_d = imem.imem_rdata;
            end
        end else if (skid_v_q) begin
            skid_v_d   = 1'b0;
            if_valid_d = 1'b1;
            if_pc_d    = skid_pc_q;
            if_instr_d = skid_instr_q;
        end else if (req_v_q) begin
            if_valid_d = 1'b1;
            if_pc_d    = req_pc_q;
            if_instr_d = imem.imem_rdata;
        end else begin
            if_valid_d = 1'b0;
            if_instr_d = NOP_INSTR;
        end
    end

    // State registers; reset drops every in-flight and buffered word.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q         <= RESET_PC;
            req_v_q      <= 1'b0;
            req_pc_q     <= RESET_PC;
            skid_v_q     <= 1'b0;
            skid_pc_q    <= RESET_PC;
            skid_instr_q <= NOP_INSTR;
            if_valid_q   <= 1'b0;
            if_pc_q      <= RESET_PC;
            if_instr_q   <= NOP_INSTR;
        end else begin
            pc_q         <= pc_d;
            req_v_q      <= req_v_d;
            req_pc_q     <= req_pc_d;
            skid_v_q     <= skid_v_d;
            skid_pc_q    <= skid_pc_d;
            skid_instr_q <= skid_instr_d;
            if_valid_q   <= if_valid_d;
            if_pc_q      <= if_pc_d;
            if_instr_q   <= if_instr_d;
        end
    end

    assign if_valid  = if_valid_q;
    assign if_pc     = if_pc_q;
    assign if_instr  = if_instr_q;
    assign if_opcode = if_instr_q[31:27];
    assign if_imm    = if_instr_q[26];

`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetch_cnt_q, perf_fetch_cnt_d;
    logic [31:0] perf_bubble_cnt_q, perf_bubble_cnt_d;
    logic        load_valid;
    logic        load_bubble;

    // Classify what the output register loads this cycle; a held register loads nothing.
    always_comb begin
        load_valid  = !branch_taken && !stall && (skid_v_q || req_v_q);
        load_bubble = branch_taken || (!stall && !skid_v_q && !req_v_q);
        perf_fetch_cnt_d  = perf_fetch_cnt_q;
        perf_bubble_cnt_d = perf_bubble_cnt_q;
        if (load_valid && (perf_fetch_cnt_q != '1)) begin
            perf_fetch_cnt_d = perf_fetch_cnt_q + 32'd1;
        end
        if (load_bubble && (perf_bubble_cnt_q != '1)) begin
            perf_bubble_cnt_d = perf_bubble_cnt_q + 32'd1;
        end
    end

    // Saturating counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_fetch_cnt_q  <= '0;
            perf_bubble_cnt_q <= '0;
        end else begin
            perf_fetch_cnt_q  <= perf_fetch_cnt_d;
            perf_bubble_cnt_q <= perf_bubble_cnt_d;
        end
    end

    assign perf_fetch_cnt  = perf_fetch_cnt_q;
    assign perf_bubble_cnt = perf_bubble_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: a transaction-level model (queue of
// outstanding fetch addresses) is checked every cycle, plus hand-computed
// literal expectations at the key points of each scenario.
module tb_fetch_stage;
    localparam int          PC_W     = 32;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP      = 32'h6800_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic        branch_taken = 1'b0;
    logic [31:0] branch_pc = '0;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_instr;
    logic [4:0]  if_opcode;
    logic        if_imm;
`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetch_cnt;
    logic [31:0] perf_bubble_cnt;
`endif

    int total = 0;
    int bad   = 0;

    fetch_stage_if #(.PC_W(PC_W)) imem_bus ();

    fetch_stage #(
        .PC_W      (PC_W),
        .RESET_PC  (RESET_PC),
        .NOP_INSTR (NOP)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .stall        (stall),
        .branch_taken (branch_taken),
        .branch_pc    (branch_pc),
        .imem         (imem_bus.master),
        .if_valid     (if_valid),
        .if_pc        (if_pc),
        .if_instr     (if_instr),
        .if_opcode    (if_opcode),
        .if_imm       (if_imm)
`ifdef FETCH_PERF_EN
        ,
        .perf_fetch_cnt  (perf_fetch_cnt),
        .perf_bubble_cnt (perf_bubble_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Memory content: the word address of each location.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a >> 2;
    endfunction

    // Synchronous memory; outside a valid response the data bus carries junk.
    always @(posedge clk) begin
        imem_bus.imem_rdata <= imem_bus.imem_en ? mem_word(imem_bus.imem_addr) : 32'hDEAD_BEEF;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [31:0] inflight[$];
    logic [31:0] m_pc;
    logic        m_valid;
    logic [31:0] m_ifpc;
    logic [31:0] m_instr;
    logic [31:0] m_fetch;
    logic [31:0] m_bubble;
    bit          started = 0;

    initial begin
        forever begin
            @(posedge clk);
            if (rst) begin
                inflight.delete();
                m_pc     = RESET_PC;
                m_valid  = 1'b0;
                m_ifpc   = RESET_PC;
                m_instr  = NOP;
                m_fetch  = '0;
                m_bubble = '0;
                started  = 1;
            end else if (branch_taken) begin
                inflight.delete();
                m_pc    = branch_pc & ~32'd3;
                m_valid = 1'b0;
                m_instr = NOP;
                if (m_bubble != '1) m_bubble = m_bubble + 1;
            end else if (!stall) begin
                if (inflight.size() > 0) begin
                    m_ifpc  = inflight.pop_front();
                    m_valid = 1'b1;
                    m_instr = mem_word(m_ifpc);
                    if (m_fetch != '1) m_fetch = m_fetch + 1;
                end else begin
                    m_valid = 1'b0;
                    m_instr = NOP;
                    if (m_bubble != '1) m_bubble = m_bubble + 1;
                end
                inflight.push_back(m_pc);
                m_pc = m_pc + 32'd4;
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    initial begin
        forever begin
            @(negedge clk);
            if (started) begin
                check("if_valid", {31'b0, if_valid}, {31'b0, m_valid});
                if (m_valid) check("if_pc", if_pc, m_ifpc);
                check("if_instr", if_instr, m_instr);
                check("if_opcode", {27'b0, if_opcode}, {27'b0, m_instr[31:27]});
                check("if_imm", {31'b0, if_imm}, {31'b0, m_instr[26]});
                check("imem_en", {31'b0, imem_bus.imem_en},
                      {31'b0, (!rst && !stall && !branch_taken)});
                check("imem_addr", imem_bus.imem_addr, m_pc);
`ifdef FETCH_PERF_EN
                check("perf_fetch_cnt", perf_fetch_cnt, m_fetch);
                check("perf_bubble_cnt", perf_bubble_cnt, m_bubble);
`endif
            end
        end
    end

    // Drive one cycle of inputs just after the edge, then return at mid-cycle.
    task automatic tick(input logic r, input logic s, input logic b, input logic [31:0] bp);
        @(posedge clk);
        #1;
        rst          = r;
        stall        = s;
        branch_taken = b;
        branch_pc    = bp;
        $display("cycle t=%0t rst=%0b stall=%0b br=%0b bpc=%h", $time, r, s, b, bp);
        @(negedge clk);
    endtask

    // ---------------- directed stimulus ----------------
    initial begin
        tick(1, 0, 0, 0);
        tick(1, 0, 0, 0);
        check("rst_valid", {31'b0, if_valid}, 32'd0);
        check("rst_pc", if_pc, 32'h0);
        check("rst_instr", if_instr, 32'h6800_0000);
        check("rst_en", {31'b0, imem_bus.imem_en}, 32'd0);

        // Reset release and streaming.
        tick(0, 0, 0, 0);                          // c0
        check("c0_en", {31'b0, imem_bus.imem_en}, 32'd1);
        check("c0_addr", imem_bus.imem_addr, 32'h0);
        tick(0, 0, 0, 0);                          // c1
        check("c1_valid", {31'b0, if_valid}, 32'd0);
        tick(0, 0, 0, 0);                          // c2
        check("c2_valid", {31'b0, if_valid}, 32'd1);
        check("c2_pc", if_pc, 32'h0);

        // Stall for 3 cycles while PC 8 is in flight.
        for (int i = 0; i < 3; i++) begin          // c3..c5
            tick(0, 1, 0, 0);
            check("stall_pc", if_pc, 32'h4);
        end
        tick(0, 0, 0, 0);                          // c6
        tick(0, 0, 0, 0);                          // c7
        check("post_stall_pc8", if_pc, 32'h8);
        check("post_stall_instr8", if_instr, 32'h2);
        tick(0, 0, 0, 0);                          // c8
        check("post_stall_pc12", if_pc, 32'hC);

        // Redirect to an unaligned target while streaming.
        tick(0, 0, 1, 32'h0000_0103);              // c9
        tick(0, 0, 0, 0);                          // c10
        check("br_bubble1_valid", {31'b0, if_valid}, 32'd0);
        check("br_bubble1_instr", if_instr, 32'h6800_0000);
        check("br_bubble1_opcode", {27'b0, if_opcode}, 32'd13);
        check("br_addr", imem_bus.imem_addr, 32'h100);
        tick(0, 0, 0, 0);                          // c11
        check("br_bubble2_valid", {31'b0, if_valid}, 32'd0);
        tick(0, 0, 0, 0);                          // c12
        check("br_target_pc", if_pc, 32'h100);
        check("br_target_valid", {31'b0, if_valid}, 32'd1);

        // Branch and stall together while the skid buffer holds a word.
        tick(0, 1, 0, 0);                          // c13
        tick(0, 1, 1, 32'h0000_0200);              // c14
        tick(0, 0, 0, 0);                          // c15
        check("bs_bubble_valid", {31'b0, if_valid}, 32'd0);
        check("bs_addr", imem_bus.imem_addr, 32'h200);
        tick(0, 0, 0, 0);                          // c16
        tick(0, 0, 0, 0);                          // c17
        check("bs_target_pc", if_pc, 32'h200);
        tick(0, 0, 0, 0);                          // c18
        check("bs_next_pc", if_pc, 32'h204);

        // PC wrap at the top of the address space.
        tick(0, 0, 1, 32'hFFFF_FFFC);              // c19
        tick(0, 0, 0, 0);                          // c20
        check("wrap_addr_top", imem_bus.imem_addr, 32'hFFFF_FFFC);
        tick(0, 0, 0, 0);                          // c21
        check("wrap_addr_zero", imem_bus.imem_addr, 32'h0);
        tick(0, 0, 0, 0);                          // c22
        check("wrap_pc_top", if_pc, 32'hFFFF_FFFC);
        check("wrap_imm", {31'b0, if_imm}, 32'd1);
        tick(0, 0, 0, 0);                          // c23
        check("wrap_pc_zero", if_pc, 32'h0);

        // One-cycle reset mid-stream with a parked skid entry.
        tick(0, 1, 0, 0);                          // c24
        tick(1, 0, 0, 0);                          // c25
        tick(0, 0, 0, 0);                          // c26
        check("mrst_valid", {31'b0, if_valid}, 32'd0);
        check("mrst_pc", if_pc, 32'h0);
        check("mrst_instr", if_instr, 32'h6800_0000);
        check("mrst_addr", imem_bus.imem_addr, 32'h0);
`ifdef FETCH_PERF_EN
        check("mrst_perf_fetch", perf_fetch_cnt, 32'd0);
        check("mrst_perf_bubble", perf_bubble_cnt, 32'd0);
`endif
        tick(0, 0, 0, 0);                          // c27
        tick(0, 0, 0, 0);                          // c28
        check("restart_pc0", if_pc, 32'h0);
        check("restart_valid", {31'b0, if_valid}, 32'd1);
        tick(0, 0, 0, 0);                          // c29
        check("restart_pc4", if_pc, 32'h4);
        tick(0, 0, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the 32-bit in-order pipeline. It holds the PC and issues requests to a synchronous instruction memory with 1-cycle read latency. It redirects on taken branches from execute and buffers one in-flight word across stalls. Its registered IF/OF output supplies `opcode` (instr[31:27]) and `imm` (instr[26]) directly to the control unit, and the full word and PC to operand fetch.

## Interface
- `PC_W`, 32, PC and instruction-address width.
- `RESET_PC`, 32'h0000_0000, PC loaded on reset; must be word-aligned.
- `NOP_INSTR`, 32'h6800_0000, bubble encoding (opcode 5'b01101, all other bits 0).

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous reset, active-high.
- `stall` in 1: hazard unit hold request for PC and the IF/OF register.
- `branch_taken` in 1: execute-stage redirect (isUBranch or taken BEQ/BGT).
- `branch_pc` in PC_W: redirect target; bits [1:0] are ignored and forced to 0.
- `imem_en` out 1: read request strobe.
- `imem_addr` out PC_W: read address, equal to the current PC.
- `imem_rdata` in 32: read data, valid the cycle after an `imem_en`=1 cycle.
- `if_valid` out 1: the IF/OF register holds a real instruction.
- `if_pc` out PC_W: PC of `if_instr`.
- `if_instr` out 32: fetched word; equals NOP_INSTR when `if_valid`=0.
- `if_opcode` out 5: `if_instr[31:27]`, feeds the control unit.
- `if_imm` out 1: `if_instr[26]`, feeds the control unit.

## Operation
- Internal state:
  - `pc_q`
  - request tracker `req_v_q`/`req_pc_q`
  - one-entry skid buffer `skid_v_q`/`skid_pc_q`/`skid_instr_q`
  - the IF/OF output register.
- Request issue:
  - `imem_addr`=`pc_q`, combinational.
  - `imem_en`=!`rst` && !`stall` && !`branch_taken`.
- PC update, in priority order:
  - `rst`: `pc_q`←RESET_PC.
  - `branch_taken`: `pc_q`←{`branch_pc`[PC_W-1:2],2'b00}.
  - `stall`: hold.
  - Otherwise: `pc_q`←`pc_q`+4, modulo 2^PC_W. The wrap from 32'hFFFF_FFFC to 0 is not an error.
- Request tracker: `req_v_q`←`imem_en`, `req_pc_q`←`pc_q`. A response is valid in the cycle where `req_v_q`=1.
- Response routing:
  - `branch_taken`: the response is discarded and `skid_v_q`←0.
  - `stall` with `req_v_q`: the response is captured into the skid buffer. At most one response can be outstanding, so the skid buffer never overflows.
  - Neither condition: the output register loads the skid entry if `skid_v_q`, else the response, else a bubble. Loading the skid entry clears `skid_v_q`.
  - A response and a skid entry never coexist when not stalled, because no request is issued while stalled.
- Output register:
  - `branch_taken`: loads a bubble (`if_valid`=0, `if_instr`=NOP_INSTR), even if `stall`=1.
  - `stall` without `branch_taken`: holds.
- Program order is preserved across stalls. No instruction is duplicated or dropped except those squashed by a redirect.
- Reset values: `pc_q`=RESET_PC, `req_v_q`=0, `skid_v_q`=0, `if_valid`=0, `if_pc`=RESET_PC, `if_instr`=NOP_INSTR, `imem_en`=0. Performance counters, when built, reset to 0.
- Asserting `rst` mid-operation discards all in-flight and buffered words at that edge.

## Timing
- After reset:
  - c0 is the first cycle with `rst`=0: `imem_en`=1, `imem_addr`=RESET_PC.
  - c1: data returns.
  - c2: `if_valid`=1, `if_pc`=RESET_PC.
- Steady state: one instruction per cycle. `if_pc` advances by 4 each cycle.
- Redirect seen at cycle t:
  - t+1: `if_valid`=0 and `imem_addr`=target.
  - t+2: `if_valid`=0, target word returning.
  - t+3: `if_valid`=1, `if_pc`=target.
  - Exactly 2 bubbles per redirect.
- Stall:
  - During `stall` cycles, outputs are frozen.
  - First cycle after `stall` falls: the skid word (if any) is presented and a new request issues at `pc_q`.
- Simultaneous `branch_taken` and `stall`: the branch wins.

## Configuration
- `FETCH_PERF_EN`
  - Defined: adds outputs `perf_fetch_cnt` [31:0] and `perf_bubble_cnt` [31:0].
    - `perf_fetch_cnt` increments on each `if_valid`=1 load.
    - `perf_bubble_cnt` increments on each cycle where the output register loads a bubble.
    - Both counters are saturating, not wrapping.
  - Undefined: the ports and logic are absent; fetch behaviour is identical either way.

## Test plan
- Reset release with RESET_PC=0 and memory returning the word address → `if_pc` sequence 0,4,8,12 starting in c2, `if_valid` continuous.
- 3-cycle `stall` asserted while the word for PC 8 is in flight → `if_pc` holds at 4 for 3 cycles, then shows 8, 12 in order with no gap, duplicate or loss.
- `branch_taken`=1, `branch_pc`=32'h0000_0103, while streaming → 2 bubbles with `if_instr`=32'h6800_0000 and `if_opcode`=5'b01101, then `if_pc`=32'h100.
- `branch_taken` and `stall` asserted together while the skid buffer holds a word → skid word discarded, redirect taken, `if_pc`=target after 2 bubbles.
- Set `pc_q` to 32'hFFFF_FFFC via branch → next `if_pc` values 32'hFFFF_FFFC, then 32'h0000_0000.
- `rst` asserted for 1 cycle mid-stream with a stalled skid entry → all outputs at reset values the next cycle; fetch restarts at RESET_PC; with `FETCH_PERF_EN`, both counters read 0.
